conv_stream_host: RTL

// - Initiator/sink for the conv_<X>_<F>_<T>_<P> streaming interface: buffers one input frame written by host,

---
 rtl/conv_stream_host.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_stream_host.sv
// conv_stream_host: host-side initiator/sink for one conv streaming instance.
// Holds one input frame written by the host and streams it out on x_*.
// Collects SIZE_X-SIZE_F+1 results from y_* into a buffer the host can read.
// Optional build macro CONV_STREAM_HOST_THROTTLE_EN: an LFSR randomly withholds
// new x offers and y_ready so the conv back-pressure paths get exercised.
`timescale 1ns/1ps

module conv_stream_host #(
    parameter int T      = 16,
    parameter int SIZE_X = 96,
    parameter int SIZE_F = 65
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   h_wr_en,
    input  logic signed [T-1:0]                    h_wr_data,
    input  logic                                   h_start,
    input  logic [$clog2(SIZE_X-SIZE_F+1)-1:0]     h_rd_addr,
    output logic signed [T-1:0]                    h_rd_data,
    output logic                                   busy,
    output logic                                   done,
    output logic signed [T-1:0]                    x_data,
    output logic                                   x_valid,
    input  logic                                   x_ready,
    input  logic signed [T-1:0]                    y_data,
    input  logic                                   y_valid,
    output logic                                   y_ready
);

    localparam int N_Y = SIZE_X - SIZE_F + 1;
    localparam int XA  = $clog2(SIZE_X);
    localparam int XW  = $clog2(SIZE_X) + 1;
    localparam int YA  = $clog2(N_Y);
    localparam int YW  = $clog2(N_Y) + 1;

    localparam logic [XW-1:0] X_FULL   = XW'(SIZE_X);
    localparam logic [XW-1:0] X_LAST   = XW'(SIZE_X - 1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] Y_FULL   = YW'(N_Y);
    localparam logic [YW-1:0] Y_LAST   = YW'(N_Y - 1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);
    localparam logic [YA:0]   Y_RD_LIM = (YA+1)'(N_Y);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [T-1:0] frame_mem  [SIZE_X];
    logic signed [T-1:0] result_mem [N_Y];

    logic [XW-1:0] wr_ptr;
    logic [XW-1:0] tx_cnt;
    logic [YW-1:0] rx_cnt;

    logic          x_gate;
    logic          y_gate;
    logic          x_beat;
    logic          y_beat;
    logic          wr_take;
    logic          wr_restart;
    logic          launch;
    logic          x_load;
    logic          rx_fin;
    logic [XA-1:0] rd_idx;
    logic [XA-1:0] wr_idx;

`ifdef CONV_STREAM_HOST_THROTTLE_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) that gates new handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign x_gate = lfsr[0];
    assign y_gate = lfsr[1];
`else
    assign x_gate = 1'b1;
    assign y_gate = 1'b1;
`endif

    // Handshake qualifiers and status flags, all derived from registered state.
    always_comb begin
        busy       = (state == S_SEND) || (state == S_COLLECT);
        done       = (state == S_DONE);
        y_ready    = busy && (rx_cnt != Y_FULL) && y_gate;
        x_beat     = x_valid && x_ready;
        y_beat     = y_valid && y_ready;
        wr_take    = (state == S_IDLE) && h_wr_en && (wr_ptr != X_FULL);
        wr_restart = (state == S_DONE) && h_wr_en;
        rx_fin     = (rx_cnt == Y_FULL) || (y_beat && (rx_cnt == Y_LAST));
        // After a beat fetch the following sample; while idle-in-SEND keep fetching the current one.
        x_load     = (state == S_SEND) && (x_beat ? (tx_cnt != X_LAST) : !x_valid);
        rd_idx     = tx_cnt[XA-1:0] + {{(XA-1){1'b0}}, x_beat};
        wr_idx     = wr_restart ? '0 : wr_ptr[XA-1:0];
    end

    // Next-state logic; a host write always takes priority over h_start.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!h_wr_en && h_start && (wr_ptr == X_FULL)) begin
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (x_beat && (tx_cnt == X_LAST)) begin
                    state_nx = rx_fin ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (y_beat && (rx_cnt == Y_LAST)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (h_wr_en) begin
                    state_nx = S_IDLE;
                end else if (h_start) begin
                    state_nx = S_SEND;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        launch = (state_nx == S_SEND) && (state != S_SEND);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame/result counters and the x output register with its hold-until-accepted rule.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            x_valid <= 1'b0;
            x_data  <= '0;
        end else begin
            if (wr_take) begin
                wr_ptr <= wr_ptr + X_ONE;
            end else if (wr_restart) begin
                wr_ptr <= X_ONE;
            end

            if (launch) begin
                tx_cnt  <= '0;
                rx_cnt  <= '0;
                x_valid <= 1'b0;
            end else begin
                if (y_beat) begin
                    rx_cnt <= rx_cnt + Y_ONE;
                end
                if (x_beat) begin
                    tx_cnt <= tx_cnt + X_ONE;
                end
                if (x_load) begin
                    x_data  <= frame_mem[rd_idx];
                    x_valid <= x_gate;
                end else if (x_beat) begin
                    x_valid <= 1'b0;
                end
            end
        end
    end

    // Frame buffer write port (a write from DONE restarts the frame at slot 0).
    always_ff @(posedge clk) begin
        if (wr_take || wr_restart) begin
            frame_mem[wr_idx] <= h_wr_data;
        end
    end

    // Result buffer write port; results are stored verbatim in arrival order.
    always_ff @(posedge clk) begin
        if (y_beat) begin
            result_mem[rx_cnt[YA-1:0]] <= y_data;
        end
    end

    // Registered host read port; addresses past the result count read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_rd_data <= '0;
        end else if ({1'b0, h_rd_addr} < Y_RD_LIM) begin
            h_rd_data <= result_mem[h_rd_addr];
        end else begin
            h_rd_data <= '0;
        end
    end

endmodule
